int_to_fp32: RTL
================

# int_to_fp32

Pipelined integer-to-single-precision converter for the floating-point execution unit; the reverse of the FP32-to-integer path. It accepts a 32- or 64-bit, signed or unsigned integer from the integer register file side and produces an IEEE-754 binary32 result plus fflags. It uses a two-register pipeline with valid/ready flow control and flush. It sits beside the FP-to-int converter in the FMISC pipe and uses the same rm and fflags encodings.

## Interface
- No parameters. Source width 64 and destination format binary32 are fixed.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- io_flush  in  1  kill all in-flight operations.
- io_in_valid  in  1  request valid.
- io_in_ready  out  1  request accepted when valid&&ready.
- io_int  in  64  integer source. Bits [63:32] are ignored for 32-bit ops.
- io_op  in  2  bit0: 1 = signed; bit1: 1 = 64-bit source, 0 = 32-bit source.
- io_rm  in  3  0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5–7 treated as RNE.
- io_out_valid  out  1  result valid.
- io_out_ready  in  1  consumer accepts.
- io_result  out  32  binary32 result.
- io_fflags  out  5  {NV,DZ,OF,UF,NX}. Only NX can be nonzero.

## Operation
- Stage 1 (combinational before register S1):
  - Select the source. For 32-bit ops, sign- or zero-extend io_int[31:0] according to bit0.
  - sign = signed && src[63].
  - mag = sign ? -src : src, as 64-bit unsigned. -2^63 yields 0x8000000000000000.
  - lz = clz64(mag). norm = mag << lz.
  - exp = 127 + 63 - lz (8 bits).
  - S1 stores: sign, exp, norm[63:40] (24-bit significand), guard = norm[39], sticky = |norm[38:0], zero = (mag == 0), rm.
- Stage 2 (combinational before register S2):
  - Round increment per rm:
    - RNE: g && (s || lsb).
    - RTZ: 0.
    - RDN: sign && (g || s).
    - RUP: !sign && (g || s).
    - RMM: g.
  - 25-bit sum. On carry-out, the significand becomes 0x800000 and exp increments.
  - Pack {sign, exp, sig[22:0]}. For zero, output +0 (0x00000000) regardless of rm.
  - NX = g || s. No other flag can be set, because overflow is impossible (max 2^64 is far below 2^128).
- Flow control:
  - S2 advances when !out_valid || io_out_ready.
  - S1 advances into S2 when S2 advances.
  - io_in_ready = !s1_valid || s2_advance. This is a combinational path from io_out_ready, and it is intended.
- Flush: on a cycle with io_flush = 1, both valid bits clear at the next edge. A request handshaked in the same cycle is discarded.

## Timing
- Latency is 2 cycles from accept to io_out_valid with no backpressure.
- Throughput is 1 per cycle.
- Reset values: io_out_valid = 0, io_result = 0, io_fflags = 0, internal valids = 0. io_in_ready = 1 out of reset.
- Data registers load only on advance. Outputs hold stable while out_valid && !out_ready.
- Reset asserted mid-operation drops all in-flight ops immediately, asynchronously. Nothing is emitted after release.
- Simultaneous flush and io_out_ready: the current output is treated as consumed, and nothing new appears next cycle.
- When both stages are full and io_out_ready = 0: io_in_ready = 0, and no op is lost or duplicated.

## Configuration
- INT_TO_FP_ONE_STAGE_EN defined:
  - Register S1 is removed and stage 1 feeds stage 2 combinationally.
  - Latency is 1 cycle.
  - io_in_ready = !out_valid || io_out_ready.
- Undefined (default): the two-register pipeline described above.
- Results and fflags are bit-identical in both modes.

## Structure
- Shared FPU package holds:
  - rm constants (RM_RNE..RM_RMM).
  - fflags bit indices.
  - io_op field positions.
  - the FP32 bias/width constants.
- Sub-module clz64: combinational 64-bit leading-zero count, 7-bit output; returns 64 for zero input. Its output is needed for the exponent only when mag != 0.

## Test plan
- Unsigned64 1, RNE -> 0x3F800000, fflags 0, out_valid exactly 2 cycles after accept. Signed64 -1 -> 0xBF800000. 0 -> 0x00000000 under every rm.
- Unsigned64 0x0000000001000001:
  - RNE -> 0x4B800000, NX.
  - RUP -> 0x4B800001, NX.
  - RTZ -> 0x4B800000, NX.
- Signed64 0x8000000000000000 -> 0xDF000000, no NX.
- Unsigned64 0xFFFFFFFFFFFFFFFF:
  - RNE -> 0x5F800000 (carry-out exponent bump), NX.
  - RTZ -> 0x5F7FFFFF, NX.
- Signed32 with io_int = 0x12345678FFFFFFFF -> 0xBF800000 (upper bits ignored). The same value as unsigned32 -> 0x4F800000, NX.
- Stream 6 back-to-back ops with io_out_ready held low for 3 cycles:
  - io_in_ready drops once both stages are full.
  - Results are in order with no loss or duplication.
- Flush and mid-stream reset each empty the pipe with zero further out_valid.

Source files
------------

// File: rtl/int_to_fp32_pkg.sv
// Shared FPU constants for the integer-to-binary32 converter: rounding modes,
// fflags bit positions, io_op fields, FP32 format and the stage-1 payload.
package int_to_fp32_pkg;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam int FFLAG_NX = 0;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_NV = 4;

  localparam int OP_SIGNED = 0;
  localparam int OP_64     = 1;

  localparam int SRC_W      = 64;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_BIAS  = 127;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W:0]   sig;
    logic                  guard;
    logic                  sticky;
    logic                  zero;
    logic [2:0]            rm;
  } s1_t;

  // Encodings 5-7 fall through to round-to-nearest-even.
  function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                     input logic lsb, input logic g, input logic s);
    logic inc;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | s);
      RM_RUP:  inc = ~sign & (g | s);
      RM_RMM:  inc = g;
      default: inc = g & (s | lsb);
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/int_to_fp32_clz64.sv
// 64-bit leading-zero count; a zero input reports 64.
module int_to_fp32_clz64 (
  input  logic [63:0] in,
  output logic [6:0]  cnt
);

  always_comb begin
    cnt = 7'd64;
    for (int i = 0; i < 64; i++)
      if (in[i]) cnt = 7'(63 - i);
  end

endmodule

// File: rtl/int_to_fp32.sv
// Pipelined 32/64-bit signed/unsigned integer to IEEE binary32 converter.
// Define INT_TO_FP_ONE_STAGE_EN to drop the S1 register (1-cycle latency).
module int_to_fp32
  import int_to_fp32_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        io_flush,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [63:0] io_int,
  input  logic [1:0]  io_op,
  input  logic [2:0]  io_rm,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_result,
  output logic [4:0]  io_fflags
);

`ifdef INT_TO_FP_ONE_STAGE_EN
  localparam int STAGES = 1;
`else
  localparam int STAGES = 2;
`endif

  localparam logic [FP32_EXP_W-1:0] EXP_TOP = FP32_EXP_W'(FP32_BIAS + SRC_W - 1);

  logic [STAGES:0] vld_pipe;
  logic            s2_adv;

  // ---- stage 1: extend, magnitude, normalize ----
  logic [63:0] src, mag, norm;
  logic [6:0]  lz;
  logic        neg;
  s1_t         s1_d, s2_in;

  assign src  = io_op[OP_64] ? io_int
                             : {{32{io_op[OP_SIGNED] & io_int[31]}}, io_int[31:0]};
  assign neg  = io_op[OP_SIGNED] & src[63];
  assign mag  = neg ? (~src + 64'd1) : src;

  int_to_fp32_clz64 u_clz (.in(mag), .cnt(lz));

  assign norm = mag << lz;

  always_comb begin
    s1_d        = '0;
    s1_d.sign   = neg;
    s1_d.exp    = EXP_TOP - {1'b0, lz};
    s1_d.sig    = norm[63:40];
    s1_d.guard  = norm[39];
    s1_d.sticky = |norm[38:0];
    s1_d.zero   = (mag == 64'd0);
    s1_d.rm     = io_rm;
  end

  // ---- stage 2: round and pack ----
  logic                  inc;
  logic [FP32_MAN_W+1:0] sum;
  logic [FP32_EXP_W-1:0] exp_r;
  logic [31:0]           res_d;
  logic [4:0]            flags_d;

  assign inc   = round_inc(s2_in.rm, s2_in.sign, s2_in.sig[0], s2_in.guard, s2_in.sticky);
  assign sum   = {1'b0, s2_in.sig} + 25'(inc);
  assign exp_r = s2_in.exp + 8'(sum[24]);

  always_comb begin
    // Carry-out leaves sig = 0x800000, whose stored mantissa is all zeros.
    res_d            = s2_in.zero ? 32'd0
                                  : {s2_in.sign, exp_r, sum[24] ? 23'd0 : sum[22:0]};
    flags_d          = '0;
    flags_d[FFLAG_NX] = s2_in.guard | s2_in.sticky;
  end

  // ---- flow control ----
  assign vld_pipe[0]  = io_in_valid;
  assign io_out_valid = vld_pipe[STAGES];
  assign s2_adv       = ~vld_pipe[STAGES] | io_out_ready;

`ifdef INT_TO_FP_ONE_STAGE_EN
  assign io_in_ready = s2_adv;
  assign s2_in       = s1_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        vld_pipe[1] <= 1'b0;
    else if (io_flush) vld_pipe[1] <= 1'b0;
    else if (s2_adv)   vld_pipe[1] <= vld_pipe[0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_result <= '0;
      io_fflags <= '0;
    end else if (s2_adv && vld_pipe[0]) begin
      io_result <= res_d;
      io_fflags <= flags_d;
    end
  end
`else
  s1_t s1_q;

  assign io_in_ready = ~vld_pipe[1] | s2_adv;
  assign s2_in       = s1_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe[1] <= 1'b0;
      vld_pipe[2] <= 1'b0;
    end else if (io_flush) begin
      vld_pipe[1] <= 1'b0;
      vld_pipe[2] <= 1'b0;
    end else begin
      if (io_in_ready) vld_pipe[1] <= vld_pipe[0];
      if (s2_adv)      vld_pipe[2] <= vld_pipe[1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                        s1_q <= '0;
    else if (io_in_ready && vld_pipe[0]) s1_q <= s1_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_result <= '0;
      io_fflags <= '0;
    end else if (s2_adv && vld_pipe[1]) begin
      io_result <= res_d;
      io_fflags <= flags_d;
    end
  end
`endif

endmodule
